// File: rtl/z80_bus_pkg.sv
// Shared Z80 I/O bus definitions: FSM state encoding, T-state / half-state
// indices and the VDP port base address used by the master and its bench.
package z80_bus_pkg;

  // Bus cycle states of the I/O master.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    REC  = 3'd5
  } z80_state_t;

  // T-state positions inside an I/O cycle with no extra waits.
  localparam int T1_IDX             = 0;
  localparam int T2_IDX             = 1;
  localparam int TW_IDX             = 2;
  localparam int T3_IDX             = 3;
  localparam int T_STATES_PER_CYCLE = 4;

  // Half-state indices within one T-state.
  localparam logic PHASE_FIRST  = 1'b0;
  localparam logic PHASE_SECOND = 1'b1;

  // VDP I/O window base (ports 0x98..0x9B).
  localparam logic [7:0] PORT_VDP_BASE = 8'h98;

  // Ceiling on extra TW states when wait_n is honoured.
  localparam logic [7:0] MAX_EXTRA_WAITS = 8'd255;

endpackage

// File: rtl/z80_tstate_timer.sv
// Half-T-state timer: counts HALF_CLKS clocks per half and toggles the phase
// bit at the end of every half. Restarted by the FSM when a request is accepted.
module z80_tstate_timer
  import z80_bus_pkg::*;
#(
  parameter int HALF_CLKS = 4,
  parameter int CW        = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          restart,
  output logic          half_tick,
  output logic          phase,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CLKS - 1);

  assign half_tick = (cnt == CNT_LAST);

  // Free-running half counter with phase toggle; restart zeroes both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= PHASE_FIRST;
    end else if (restart) begin
      cnt   <= '0;
      phase <= PHASE_FIRST;
    end else if (half_tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/z80_io_master.sv
// Z80 I/O bus initiator: turns single-word local requests into IN/OUT cycles
// (T1, T2, TW, T3, optional recovery). Every bus output is a register whose
// next value is decoded from the FSM's next state and the timer's next phase,
// so pins line up exactly with the T-state boundaries.
// Build option: define Z80_IO_WAIT_EN to honour wait_n (up to 255 extra TWs,
// sticky wait_timeout output); otherwise wait_n is ignored and one TW is used.
//
// Handshake: a request is taken on any clock where req & ready; wr/port/wdata
// are latched on that edge, ready drops on that edge, T1 starts the next
// clock. req while ready=0 is ignored and nothing is queued.
module z80_io_master
  import z80_bus_pkg::*;
#(
  parameter int         HALF_CLKS  = 4,
  parameter logic [7:0] PORT_BASE  = PORT_VDP_BASE,
  parameter int         RECOVERY_T = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  output logic       ready,
  input  logic       wr,
  input  logic [1:0] port,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic [7:0] addr,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] cd_o,
  output logic       cd_oe,
  input  logic [7:0] cd_i,
  input  logic       wait_n,
  input  logic       int_n,
  output logic       int_pending,
  output z80_state_t dbg_state
`ifdef Z80_IO_WAIT_EN
  ,
  output logic       wait_timeout
`endif
);

  localparam int            CW         = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam logic [CW-1:0] CNT_PENULT = CW'(HALF_CLKS - 2);
  localparam logic [2:0]    REC_LAST   = 3'(RECOVERY_T - 1);

  z80_state_t    state_q, state_d;
  logic          wr_q;
  logic [2:0]    rec_q, rec_d;
  logic          accept, t_end, phase_d;
  logic          half_tick, phase;
  logic [CW-1:0] cnt;
  logic          strobe_d, oe_d, done_d, rd_cap;

`ifdef Z80_IO_WAIT_EN
  logic [7:0]    extra_q, extra_d;
  logic          timeout_d;
`else
  logic          unused_wait;
  assign unused_wait = wait_n;
`endif

  assign dbg_state = state_q;

  z80_tstate_timer #(
    .HALF_CLKS (HALF_CLKS),
    .CW        (CW)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (accept),
    .half_tick (half_tick),
    .phase     (phase),
    .cnt       (cnt)
  );

  // Next-state logic: T-states advance at the end of the second half.
  always_comb begin
    accept  = req && (state_q == IDLE);
    t_end   = half_tick && (phase == PHASE_SECOND);
    phase_d = accept ? PHASE_FIRST : (half_tick ? ~phase : phase);
    state_d = state_q;
    rec_d   = rec_q;
`ifdef Z80_IO_WAIT_EN
    extra_d   = extra_q;
    timeout_d = wait_timeout;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = T1;
`ifdef Z80_IO_WAIT_EN
          extra_d = '0;
`endif
        end
      end
      T1: if (t_end) state_d = T2;
      T2: if (t_end) state_d = TW;
      TW: begin
        if (t_end) begin
`ifdef Z80_IO_WAIT_EN
          if (!wait_n && (extra_q != MAX_EXTRA_WAITS)) begin
            extra_d = extra_q + 8'd1;
          end else begin
            if (!wait_n) timeout_d = 1'b1;
            state_d = T3;
          end
`else
          state_d = T3;
`endif
        end
      end
      T3: begin
        if (t_end) begin
          rec_d   = '0;
          state_d = (RECOVERY_T == 0) ? IDLE : REC;
        end
      end
      REC: begin
        if (t_end) begin
          if (rec_q == REC_LAST) state_d = IDLE;
          else                   rec_d   = rec_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode of the next bus pin values from the next state and phase.
  always_comb begin
    strobe_d = (state_d == T2) || (state_d == TW) ||
               ((state_d == T3) && (phase_d == PHASE_FIRST));
    oe_d     = wr_q && (((state_d == T1) && (phase_d == PHASE_SECOND)) ||
                        (state_d == T2) || (state_d == TW) || (state_d == T3));
    done_d   = (state_q == T3) && (phase == PHASE_SECOND) && (cnt == CNT_PENULT);
    rd_cap   = !wr_q && (state_q == T3) && (phase == PHASE_FIRST) && half_tick;
  end

  // FSM and request latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rec_q   <= '0;
      wr_q    <= 1'b0;
`ifdef Z80_IO_WAIT_EN
      extra_q      <= '0;
      wait_timeout <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      if (accept) wr_q <= wr;
`ifdef Z80_IO_WAIT_EN
      extra_q      <= extra_d;
      wait_timeout <= timeout_d;
`endif
    end
  end

  // Registered bus pins, handshake outputs and read data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready  <= 1'b1;
      done   <= 1'b0;
      rdata  <= '0;
      addr   <= '0;
      iorq_n <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      cd_o   <= '0;
      cd_oe  <= 1'b0;
    end else begin
      ready  <= (state_d == IDLE);
      done   <= done_d;
      iorq_n <= ~strobe_d;
      rd_n   <= ~(strobe_d && !wr_q);
      wr_n   <= ~(strobe_d && wr_q);
      cd_oe  <= oe_d;
      if (accept) begin
        addr <= {PORT_BASE[7:2], port};
        cd_o <= wdata;
      end
      if (rd_cap) rdata <= cd_i;
    end
  end

  // Interrupt request flag, independent of the bus FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) int_pending <= 1'b0;
    else          int_pending <= ~int_n;
  end

endmodule

// File: tb/tb_z80_io_master.sv
// Bench for z80_io_master with HALF_CLKS=4 (8 clocks per T-state) and
// RECOVERY_T=1. Clock 0 is the first T1 clock after the accepting edge.
// Expected per-clock pin vectors are queued when a request is issued and
// popped and compared every clock while the cycle runs.
module tb_z80_io_master;
  import z80_bus_pkg::*;

  localparam int HALF = 4;
  localparam int TCLK = 2 * HALF;
  localparam int W    = 33;

  logic       clk;
  logic       reset_n;
  logic       req;
  logic       ready;
  logic       wr;
  logic [1:0] port;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       done;
  logic [7:0] addr;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] cd_o;
  logic       cd_oe;
  logic [7:0] cd_i;
  logic       wait_n;
  logic       int_n;
  logic       int_pending;
  z80_state_t dbg_state;
`ifdef Z80_IO_WAIT_EN
  logic       wait_timeout;
`endif

  logic [W-1:0] exp_q[$];
  logic [7:0]   model_rdata;
  int           checks;
  int           errors;

  z80_io_master #(
    .HALF_CLKS  (HALF),
    .PORT_BASE  (PORT_VDP_BASE),
    .RECOVERY_T (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .ready        (ready),
    .wr           (wr),
    .port         (port),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .addr         (addr),
    .iorq_n       (iorq_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .cd_o         (cd_o),
    .cd_oe        (cd_oe),
    .cd_i         (cd_i),
    .wait_n       (wait_n),
    .int_n        (int_n),
    .int_pending  (int_pending),
    .dbg_state    (dbg_state)
`ifdef Z80_IO_WAIT_EN
    ,
    .wait_timeout (wait_timeout)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One clock step; leaves time 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_obs();
    return {dbg_state, addr, cd_o, rdata, iorq_n, rd_n, wr_n, cd_oe, done, ready};
  endfunction

  // Present a request and let the accepting edge pass; returns at clock 0.
  task automatic start_req(input logic w, input logic [1:0] p, input logic [7:0] d);
    req   = 1'b1;
    wr    = w;
    port  = p;
    wdata = d;
    tick();
  endtask

  // Queue the expected pin vector for clocks 0 .. end of recovery (ready back).
  task automatic push_cycle(input logic is_wr, input logic [1:0] p, input logic [7:0] wd,
                            input int extra, input logic [7:0] rd_val);
    int         len;
    logic [7:0] base;
    logic [7:0] a;
    len  = 4 * TCLK + extra * TCLK;
    base = PORT_VDP_BASE;
    a    = {base[7:2], p};
    for (int k = 0; k <= len + TCLK; k++) begin
      z80_state_t st;
      logic       strobe, oe, dn, rdy;
      logic [7:0] rdv;
      st = (k < TCLK)       ? T1 :
           (k < 2 * TCLK)   ? T2 :
           (k < len - TCLK) ? TW :
           (k < len)        ? T3 :
           (k < len + TCLK) ? REC : IDLE;
      strobe = (k >= TCLK) && (k < len - HALF);
      oe     = is_wr && (k >= HALF) && (k < len);
      dn     = (k == len - 1);
      rdy    = (k == len + TCLK);
      rdv    = (!is_wr && (k >= len - HALF)) ? rd_val : model_rdata;
      exp_q.push_back({st, a, wd, rdv, ~strobe, ~(strobe && !is_wr), ~(strobe && is_wr),
                       oe, dn, rdy});
    end
    if (!is_wr) model_rdata = rd_val;
  endtask

  // Run n clocks, driving wait_n / cd_i windows and comparing against the queue.
  task automatic run_clocks(input int n, input int req_off_at, input int wlo_from,
                            input int wlo_to, input logic [7:0] cd_val, input int cd_from,
                            input int cd_to, input string tag);
    for (int k = 0; k < n; k++) begin
      if (k == req_off_at) req = 1'b0;
      wait_n = !((k >= wlo_from) && (k < wlo_to));
      cd_i   = ((k >= cd_from) && (k <= cd_to)) ? cd_val : ~cd_val;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_queue_empty: observed empty queue at clock %0d expected entry", tag, k);
      end else begin
        check($sformatf("%s_clk%0d", tag, k), pack_obs(), exp_q.pop_front());
      end
      tick();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_rdata = 8'h00;
    reset_n     = 1'b0;
    req         = 1'b0;
    wr          = 1'b0;
    port        = 2'd0;
    wdata       = 8'h00;
    cd_i        = 8'h00;
    wait_n      = 1'b1;
    int_n       = 1'b1;

    // Reset values
    repeat (3) tick();
    check("reset_bus", pack_obs(),
          {IDLE, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    check("reset_int", int_pending, 0);
`ifdef Z80_IO_WAIT_EN
    check("reset_timeout", wait_timeout, 0);
`endif
    reset_n = 1'b1;
    repeat (2) tick();

    // Write: port 1, data 5A -> address 99
    start_req(1'b1, 2'd1, 8'h5A);
    push_cycle(1'b1, 2'd1, 8'h5A, 0, 8'h00);
    run_clocks(41, 0, -1, -1, 8'h00, -1, -1, "wr");
    check("wr_addr_hold", addr, 8'h99);

    // Read: port 0, C3 on the bus only during clocks 20..27
    start_req(1'b0, 2'd0, 8'hEE);
    push_cycle(1'b0, 2'd0, 8'hEE, 0, 8'hC3);
`ifdef Z80_IO_WAIT_EN
    run_clocks(41, 0, -1, -1, 8'hC3, 20, 27, "rd");
`else
    // wait_n is ignored in this build, so pulling it low changes nothing
    run_clocks(41, 0, 16, 36, 8'hC3, 20, 27, "rd");
`endif
    check("rd_rdata_hold", rdata, 8'hC3);

    // Back-to-back: req held high; second request data present during the first cycle
    start_req(1'b1, 2'd2, 8'hA5);
    push_cycle(1'b1, 2'd2, 8'hA5, 0, 8'h00);
    wr    = 1'b0;
    port  = 2'd3;
    wdata = 8'h11;
    push_cycle(1'b0, 2'd3, 8'h11, 0, 8'h7E);
    run_clocks(82, 41, -1, -1, 8'h7E, 41 + 20, 41 + 27, "b2b");
    check("b2b_addr", addr, 8'h9B);

`ifdef Z80_IO_WAIT_EN
    // Wait: wait_n low for 20 clocks from clock 16 -> two extra TWs
    start_req(1'b1, 2'd0, 8'h3C);
    push_cycle(1'b1, 2'd0, 8'h3C, 2, 8'h00);
    run_clocks(57, 0, 16, 36, 8'h00, -1, -1, "wait");
    check("wait_timeout_clear", wait_timeout, 0);
`endif

    // Reset in the middle of a write at clock 12
    start_req(1'b1, 2'd1, 8'h5A);
    push_cycle(1'b1, 2'd1, 8'h5A, 0, 8'h00);
    run_clocks(12, 0, -1, -1, 8'h00, -1, -1, "rst");
    check("rst_pre_strobes", {iorq_n, wr_n, cd_oe}, 3'b001);
    reset_n = 1'b0;
    #1;
    check("rst_async", {iorq_n, rd_n, wr_n, cd_oe, done, ready}, 6'b111001);
    exp_q.delete();
    model_rdata = 8'h00;
    repeat (2) begin
      tick();
      check("rst_hold", {iorq_n, rd_n, wr_n, cd_oe, done}, 5'b11100);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("rst_idle_%0d", k), {dbg_state, iorq_n, wr_n, cd_oe, done, ready},
            {IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    check("rst_rdata", rdata, 8'h00);
    check("rst_addr", addr, 8'h00);

    // Interrupt flag follows int_n one clock later in both directions
    int_n = 1'b0;
    check("int_before_edge", int_pending, 0);
    tick();
    check("int_set", int_pending, 1);
    int_n = 1'b1;
    check("int_hold", int_pending, 1);
    tick();
    check("int_clear", int_pending, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
